bd_word_serializer: RTL and testbench

Parametrised serializer between the BD decoder and the PC upstream path. It accepts one decoded BD word per handshake and splits its payload into 1..MaxChunks chunks of Nout bits, using a per-leaf chunk-count table. Each chunk is emitted on the serialized PC channel with the leaf code attached. The block registers the word internally, so the decoder is released on the accept cycle rather than held for the whole word, and back-to-back words stream with no bubble.

---
 rtl/bd_ser_pkg.sv | 56 +++++
 rtl/bd_word_serializer_if.sv | 33 +++
 rtl/bd_word_serializer_chunk_mux.sv | 35 +++
 rtl/bd_word_serializer.sv | 129 ++++++++++++
 tb/tb_bd_word_serializer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bd_ser_pkg.sv
// -----------------------------------------------------------------------------
// bd_ser_pkg
// Shared definitions for the BD word serializer:
//   - leaf_t       : funnel leaf identifiers; the enum value is also the route
//                    code placed on the serialized PC channel
//   - NumLeaves    : number of leaves described by the chunk table
//   - ChunkCount   : number of Nout-bit chunks each leaf's payload occupies
//   - ser_state_t  : serializer FSM states
//   - ceil_div     : integer ceiling division
//   - table_count  : chunk-table lookup, 1 for codes beyond the table
// -----------------------------------------------------------------------------
package bd_ser_pkg;

    localparam int unsigned NumLeaves = 13;

    typedef enum logic [7:0] {
        LEAF_NRNI      = 8'd0,
        LEAF_DUMP_MM   = 8'd1,
        LEAF_DUMP_TAT0 = 8'd2,
        LEAF_DUMP_TAT1 = 8'd3,
        LEAF_RO_ACC    = 8'd4,
        LEAF_RO_TAT    = 8'd5,
        LEAF_DUMP_PRE  = 8'd6,
        LEAF_DUMP_POST = 8'd7,
        LEAF_DUMP_AM   = 8'd8,
        LEAF_DUMP_CFG  = 8'd9,
        LEAF_NRNI_ACK  = 8'd10,
        LEAF_PAT_DUMP  = 8'd11,
        LEAF_TAG_OUT   = 8'd12
    } leaf_t;

    // Index 0 is LEAF_NRNI; the two TAT dumps and both RO leaves carry wide data.
    localparam int unsigned ChunkCount [NumLeaves] = '{
        1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1
    };

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Constant-index scan keeps the lookup width-clean for any code width.
    function automatic int unsigned table_count(input int unsigned leaf);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < NumLeaves; i++) begin
            if (leaf == i) r = ChunkCount[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bd_word_serializer_if.sv
// -----------------------------------------------------------------------------
// Channel interfaces for the BD word serializer.
//   DecodedBDWordChannel    : decoded BD word from the decoder
//                             v, a, leaf_code[Ncode], payload[Nin]
//   SerializedPCWordChannel : one chunk toward the PC upstream path
//                             v, a, code[Ncode], payload[Nout]
// A transfer happens on a rising clock edge with v and a both high.
// -----------------------------------------------------------------------------
interface DecodedBDWordChannel #(
    parameter int unsigned Ncode = 8,
    parameter int unsigned Nin   = 32
);
    logic             v;
    logic             a;
    logic [Ncode-1:0] leaf_code;
    logic [Nin-1:0]   payload;

    modport master (output v, leaf_code, payload, input a);
    modport slave  (input v, leaf_code, payload, output a);
endinterface

interface SerializedPCWordChannel #(
    parameter int unsigned Ncode = 8,
    parameter int unsigned Nout  = 24
);
    logic             v;
    logic             a;
    logic [Ncode-1:0] code;
    logic [Nout-1:0]  payload;

    modport master (output v, code, payload, input a);
    modport slave  (input v, code, payload, output a);
endinterface

// File: rtl/bd_word_serializer_chunk_mux.sv
// -----------------------------------------------------------------------------
// bd_chunk_mux
// Selects chunk number idx (Nout bits wide) out of a Nin-bit word. The word is
// zero-padded up to MaxChunks*Nout bits so the top chunk reads zeros above Nin.
// Ports:
//   word  input  [Nin-1:0]   registered word
//   idx   input  [IdxW-1:0]  chunk index
//   chunk output [Nout-1:0]  selected chunk (0 for idx >= MaxChunks)
// Purely combinational.
// -----------------------------------------------------------------------------
module bd_chunk_mux #(
    parameter int unsigned Nin       = 32,
    parameter int unsigned Nout      = 24,
    parameter int unsigned MaxChunks = 2,
    parameter int unsigned IdxW      = 1
) (
    input  logic [Nin-1:0]  word,
    input  logic [IdxW-1:0] idx,
    output logic [Nout-1:0] chunk
);

    localparam int unsigned PadW = MaxChunks * Nout;

    logic [PadW-1:0] padded;

    always_comb begin
        padded          = '0;
        padded[Nin-1:0] = word;
        chunk           = '0;
        for (int unsigned k = 0; k < MaxChunks; k++) begin
            if (idx == IdxW'(k)) chunk = padded[k*Nout +: Nout];
        end
    end

endmodule

// File: rtl/bd_word_serializer.sv
// -----------------------------------------------------------------------------
// bd_word_serializer
// Accepts one decoded BD word per handshake, registers it, and emits its
// payload as 1..MaxChunks chunks of Nout bits with the leaf code attached.
// The decoder is released on the accept cycle; the next word is accepted on
// the final chunk's transfer so words stream with no bubble.
// Ports:
//   clk       input   clock
//   reset     input   synchronous, active-high
//   dec_in    DecodedBDWordChannel.slave     incoming word
//   ser_out   SerializedPCWordChannel.master outgoing chunk
//   bad_leaf  output  sticky flag: a word with leaf_code >= Nleaf was accepted
// -----------------------------------------------------------------------------
module bd_word_serializer
    import bd_ser_pkg::*;
#(
    parameter int unsigned Ncode    = 8,
    parameter int unsigned Nin      = 32,
    parameter int unsigned Nout     = 24,
    parameter int unsigned Nleaf    = NumLeaves,
    parameter bit          MsbFirst = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    DecodedBDWordChannel.slave            dec_in,
    SerializedPCWordChannel.master        ser_out,
    output logic                          bad_leaf
);

    localparam int unsigned MaxChunks = ceil_div(Nin, Nout);
    localparam int unsigned IdxW      = (MaxChunks > 1) ? $clog2(MaxChunks) : 1;

    ser_state_t      state_q, state_d;
    logic [Nin-1:0]   word_q;
    logic [Ncode-1:0] code_q;
    logic [IdxW-1:0]  last_q;
    logic [IdxW-1:0]  idx_q;
    logic [Nout-1:0]  chunk;

    logic            is_final;
    logic            in_accept;
    logic            leaf_bad;
    int unsigned     n_raw;
    int unsigned     n_clamped;
    logic [IdxW-1:0] n_last;

    assign is_final  = (idx_q == last_q);
    assign in_accept = dec_in.v && dec_in.a;
    assign leaf_bad  = 32'(dec_in.leaf_code) >= Nleaf;

    // Chunk count for the incoming word: unknown leaves get a single chunk,
    // and table entries are forced into the 1..MaxChunks range.
    always_comb begin
        n_raw = leaf_bad ? 1 : table_count(32'(dec_in.leaf_code));
        if (n_raw == 0)
            n_clamped = 1;
        else if (n_raw > MaxChunks)
            n_clamped = MaxChunks;
        else
            n_clamped = n_raw;
        n_last = IdxW'(n_clamped - 1);
    end

    bd_chunk_mux #(
        .Nin       (Nin),
        .Nout      (Nout),
        .MaxChunks (MaxChunks),
        .IdxW      (IdxW)
    ) u_mux (
        .word  (word_q),
        .idx   (idx_q),
        .chunk (chunk)
    );

    assign ser_out.code    = code_q;
    assign ser_out.payload = chunk;

    // Next state and handshake outputs. The only input-to-output path is
    // ser_out.a -> dec_in.a on the final chunk (plus the reset gate).
    always_comb begin
        state_d    = state_q;
        dec_in.a   = 1'b0;
        ser_out.v  = 1'b0;
        case (state_q)
            IDLE: begin
                dec_in.a = 1'b1;
                if (dec_in.v) state_d = SEND;
            end
            SEND: begin
                ser_out.v = 1'b1;
                if (ser_out.a && is_final) begin
                    dec_in.a = 1'b1;
                    if (!dec_in.v) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) dec_in.a = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Word register and chunk index. A new word (re)loads everything; otherwise
    // the index steps toward last_q on each non-final chunk transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            code_q   <= '0;
            last_q   <= '0;
            idx_q    <= '0;
            bad_leaf <= 1'b0;
        end else if (in_accept) begin
            word_q   <= dec_in.payload;
            code_q   <= dec_in.leaf_code;
            idx_q    <= MsbFirst ? n_last : '0;
            last_q   <= MsbFirst ? '0 : n_last;
            bad_leaf <= bad_leaf | leaf_bad;
        end else if (state_q == SEND && ser_out.a && !is_final) begin
            idx_q <= MsbFirst ? (idx_q - IdxW'(1)) : (idx_q + IdxW'(1));
        end
    end

endmodule

// File: tb/tb_bd_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_bd_word_serializer
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// compares both against a queue-based reference model of the chunk stream.
// -----------------------------------------------------------------------------
module tb_bd_word_serializer;
    import bd_ser_pkg::*;

    logic clk;
    logic reset;

    logic        tb_v;
    logic [7:0]  tb_leaf;
    logic [31:0] tb_pay;
    logic        tb_a;

    logic bad_lsb;
    logic bad_msb;

    int errors;
    int checks;
    bit bad_exp;

    logic [7:0]  word_leaf [$];
    logic [31:0] word_pay  [$];
    logic [23:0] exp_l     [$];
    logic [23:0] exp_m     [$];
    logic [7:0]  exp_code  [$];
    bit          exp_last  [$];

    DecodedBDWordChannel    #(.Ncode(8), .Nin(32))  dec_lsb ();
    SerializedPCWordChannel #(.Ncode(8), .Nout(24)) ser_lsb ();
    DecodedBDWordChannel    #(.Ncode(8), .Nin(32))  dec_msb ();
    SerializedPCWordChannel #(.Ncode(8), .Nout(24)) ser_msb ();

    assign dec_lsb.v         = tb_v;
    assign dec_lsb.leaf_code = tb_leaf;
    assign dec_lsb.payload   = tb_pay;
    assign ser_lsb.a         = tb_a;
    assign dec_msb.v         = tb_v;
    assign dec_msb.leaf_code = tb_leaf;
    assign dec_msb.payload   = tb_pay;
    assign ser_msb.a         = tb_a;

    bd_word_serializer #(
        .Ncode(8), .Nin(32), .Nout(24), .Nleaf(13), .MsbFirst(1'b0)
    ) dut_lsb (
        .clk      (clk),
        .reset    (reset),
        .dec_in   (dec_lsb),
        .ser_out  (ser_lsb),
        .bad_leaf (bad_lsb)
    );

    bd_word_serializer #(
        .Ncode(8), .Nin(32), .Nout(24), .Nleaf(13), .MsbFirst(1'b1)
    ) dut_msb (
        .clk      (clk),
        .reset    (reset),
        .dec_in   (dec_msb),
        .ser_out  (ser_msb),
        .bad_leaf (bad_msb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chunks per leaf straight from the leaf list: wide-data leaves use two.
    function automatic int ref_count(input int unsigned leaf);
        if (leaf >= 13) return 1;
        if (leaf >= 2 && leaf <= 5) return 2;
        return 1;
    endfunction

    function automatic logic [23:0] ref_chunk(input logic [31:0] pay, input int idx);
        logic [63:0] w;
        w = {32'b0, pay};
        return 24'(w >> (24 * idx));
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] leaf,
                                 input logic [31:0] pay, input logic a);
        tb_v    = v;
        tb_leaf = leaf;
        tb_pay  = pay;
        tb_a    = a;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic queueWord(input logic [7:0] leaf, input logic [31:0] pay);
        int n;
        word_leaf.push_back(leaf);
        word_pay.push_back(pay);
        n = ref_count(32'(leaf));
        for (int k = 0; k < n; k++) begin
            exp_l.push_back(ref_chunk(pay, k));
            exp_m.push_back(ref_chunk(pay, n - 1 - k));
            exp_code.push_back(leaf);
            exp_last.push_back(k == n - 1);
        end
    endtask

    // Offers queued words back-to-back and checks every cycle until the
    // model has drained. Entered and left at posedge+1 with the DUT idle.
    task automatic runStream(input int stall_start, input int stall_len, input bit rand_a);
        int   cyc;
        bit   busy;
        bit   last;
        logic a_now;
        cyc  = 0;
        busy = 1'b0;
        while ((word_leaf.size() != 0 || busy) && cyc < 400) begin
            a_now = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (rand_a) a_now = ($urandom_range(0, 3) != 0);
            if (word_leaf.size() != 0)
                applyStimulus(1'b1, word_leaf[0], word_pay[0], a_now);
            else
                applyStimulus(1'b0, 8'h00, 32'h0, a_now);
            #3;
            checkOutput("bad_leaf_lsb", 32'(bad_lsb), 32'(bad_exp));
            checkOutput("bad_leaf_msb", 32'(bad_msb), 32'(bad_exp));
            if (!busy) begin
                checkOutput("idle_v_lsb", 32'(ser_lsb.v), 32'd0);
                checkOutput("idle_v_msb", 32'(ser_msb.v), 32'd0);
                checkOutput("idle_dec_a_lsb", 32'(dec_lsb.a), 32'd1);
                checkOutput("idle_dec_a_msb", 32'(dec_msb.a), 32'd1);
                if (tb_v) begin
                    if (word_leaf[0] >= 8'd13) bad_exp = 1'b1;
                    void'(word_leaf.pop_front());
                    void'(word_pay.pop_front());
                    busy = 1'b1;
                end
            end else begin
                checkOutput("send_v_lsb", 32'(ser_lsb.v), 32'd1);
                checkOutput("send_v_msb", 32'(ser_msb.v), 32'd1);
                checkOutput("code_lsb", 32'(ser_lsb.code), 32'(exp_code[0]));
                checkOutput("code_msb", 32'(ser_msb.code), 32'(exp_code[0]));
                checkOutput("chunk_lsb", 32'(ser_lsb.payload), 32'(exp_l[0]));
                checkOutput("chunk_msb", 32'(ser_msb.payload), 32'(exp_m[0]));
                checkOutput("dec_a_lsb", 32'(dec_lsb.a), 32'(a_now && exp_last[0]));
                checkOutput("dec_a_msb", 32'(dec_msb.a), 32'(a_now && exp_last[0]));
                if (a_now) begin
                    last = exp_last[0];
                    void'(exp_l.pop_front());
                    void'(exp_m.pop_front());
                    void'(exp_code.pop_front());
                    void'(exp_last.pop_front());
                    if (last) begin
                        if (tb_v) begin
                            if (word_leaf[0] >= 8'd13) bad_exp = 1'b1;
                            void'(word_leaf.pop_front());
                            void'(word_pay.pop_front());
                        end else begin
                            busy = 1'b0;
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("stream_done", 32'(busy || word_leaf.size() != 0), 32'd0);
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_v_lsb"},    32'(ser_lsb.v),       32'd0);
        checkOutput({tag, "_v_msb"},    32'(ser_msb.v),       32'd0);
        checkOutput({tag, "_pay_lsb"},  32'(ser_lsb.payload), 32'd0);
        checkOutput({tag, "_pay_msb"},  32'(ser_msb.payload), 32'd0);
        checkOutput({tag, "_code_lsb"}, 32'(ser_lsb.code),    32'd0);
        checkOutput({tag, "_bad_lsb"},  32'(bad_lsb),         32'd0);
        checkOutput({tag, "_bad_msb"},  32'(bad_msb),         32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pay;
        errors  = 0;
        checks  = 0;
        bad_exp = 1'b0;
        reset   = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);

        // Reset state; decoder ready must be held low while reset is high.
        repeat (2) @(posedge clk);
        #1;
        #3;
        checkResetState("reset");
        checkOutput("reset_dec_a_lsb", 32'(dec_lsb.a), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // RO_TAT two-chunk word in both chunk orders.
        queueWord(LEAF_RO_TAT, 32'hDEADBEEF);
        runStream(1000, 0, 1'b0);

        // Single-chunk NRNI followed immediately by a two-chunk RO_ACC.
        queueWord(LEAF_NRNI, 32'h00000ABC);
        queueWord(LEAF_RO_ACC, 32'h00123456);
        runStream(1000, 0, 1'b0);

        // Backpressure for five cycles between the two chunks.
        queueWord(LEAF_RO_TAT, 32'hDEADBEEF);
        runStream(2, 5, 1'b0);

        // Out-of-table leaf: one chunk, sticky flag through later words.
        queueWord(8'd20, 32'h01FFFFFF);
        queueWord(LEAF_RO_TAT, $urandom);
        queueWord(LEAF_DUMP_AM, $urandom);
        runStream(1000, 0, 1'b0);

        // Random leaves, payloads and backpressure.
        for (int i = 0; i < 12; i++) queueWord(8'($urandom_range(0, 12)), $urandom);
        runStream(0, 0, 1'b1);

        // Reset after the first chunk of an RO_TAT word.
        pay = $urandom;
        applyStimulus(1'b1, LEAF_RO_TAT, pay, 1'b1);
        #3;
        checkOutput("mid_accept_dec_a", 32'(dec_lsb.a), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
        #3;
        checkOutput("mid_chunk0_lsb", 32'(ser_lsb.payload), 32'(ref_chunk(pay, 0)));
        checkOutput("mid_chunk0_msb", 32'(ser_msb.payload), 32'(ref_chunk(pay, 1)));
        @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        checkOutput("mid_reset_v_lsb", 32'(ser_lsb.v), 32'd1);
        checkOutput("mid_reset_dec_a_lsb", 32'(dec_lsb.a), 32'd0);
        checkOutput("mid_reset_dec_a_msb", 32'(dec_msb.a), 32'd0);
        @(posedge clk);
        #1;
        #3;
        bad_exp = 1'b0;
        checkResetState("mid_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // A fresh word after the reset runs normally.
        queueWord(LEAF_DUMP_MM, $urandom);
        queueWord(LEAF_DUMP_TAT1, $urandom);
        runStream(1000, 0, 1'b0);

        for (int i = 0; i < 10; i++) queueWord(8'($urandom_range(0, 12)), $urandom);
        runStream(0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
